video_grid_rx: RTL and testbench



---
 rtl/video_pkg.sv | 34 +++
 rtl/video_timing_meas.sv | 140 ++++++++++++++
 rtl/video_grid_rx.sv | 120 ++++++++++++
 tb/tb_video_grid_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared RGB565 and 8x8 bit-grid definitions used by the display
// generator and the loopback receiver.
package video_pkg;

    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;

    localparam int GRID_N     = 8;
    localparam int GRID_X_OFS = 128;
    localparam int GRID_Y_OFS = 8;
    localparam int GRID_CELL  = 32;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        LINE
    } vstate_e;

    typedef struct packed {
        logic           de;
        logic           hs;
        logic           vs;
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } lcd_t;

    // A lit cell is drawn white; red and green MSBs both set.
    function automatic logic grid_bit(input lcd_t p);
        return p.r[R_W-1] & p.g[G_W-1];
    endfunction

endpackage

// File: rtl/video_timing_meas.sv
// LCD input registers, DE/VSYNC edge detect, pixel/line counting
// and per-frame geometry measurement with lock tracking.
module video_timing_meas
    import video_pkg::*;
#(
    parameter int   CW     = 12,
    parameter logic VS_ACT = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  lcd_t          lcd_i,
    output lcd_t          pix_o,
    output logic          pix_vld_o,
    output logic [CW-1:0] pix_x_o,
    output logic [CW-1:0] pix_y_o,
    output logic          commit_o,
    output logic          frame_bad_o,
    output logic [CW-1:0] act_w_o,
    output logic [CW-1:0] act_h_o,
    output logic          locked_o
);

    localparam logic [CW-1:0] CMAX = '1;

    lcd_t          s1_q, s2_q;
    vstate_e       state_q, state_d;
    logic [CW-1:0] xcnt_q, xcnt_d;
    logic [CW-1:0] ycnt_q, ycnt_d;
    logic [CW-1:0] wref_q, wref_d;
    logic [CW-1:0] act_w_q, act_w_d;
    logic [CW-1:0] act_h_q, act_h_d;
    logic          werr_q, werr_d;
    logic          sat_q, sat_d;
    logic [1:0]    mcnt_q, mcnt_d;
    logic          vs_edge, de_rise;

    assign vs_edge = (s1_q.vs == VS_ACT) && (s2_q.vs != VS_ACT);
    assign de_rise = s1_q.de && !s2_q.de;

    // xcnt holds pixels already seen on the line, so it is also the
    // index of the pixel currently in s1.
    always_comb begin
        state_d   = state_q;
        xcnt_d    = xcnt_q;
        ycnt_d    = ycnt_q;
        wref_d    = wref_q;
        werr_d    = werr_q;
        sat_d     = sat_q;
        act_w_d   = act_w_q;
        act_h_d   = act_h_q;
        mcnt_d    = mcnt_q;
        commit_o  = 1'b0;
        pix_vld_o = 1'b0;
        pix_x_o   = xcnt_q;
        pix_y_o   = ycnt_q;
        if (vs_edge) begin
            if (state_q != IDLE) begin
                commit_o = 1'b1;
                act_w_d  = wref_q;
                act_h_d  = ycnt_q;
                if (wref_q == act_w_q && ycnt_q == act_h_q && !werr_q)
                    mcnt_d = (mcnt_q == 2'd2) ? 2'd2 : mcnt_q + 2'd1;
                else
                    mcnt_d = '0;
            end
            state_d = FRAME;
            xcnt_d  = '0;
            ycnt_d  = '0;
            werr_d  = 1'b0;
            sat_d   = 1'b0;
            pix_y_o = '0;
            if (de_rise) begin
                state_d   = LINE;
                xcnt_d    = CW'(1);
                pix_vld_o = 1'b1;
                pix_x_o   = '0;
            end
        end else begin
            unique case (state_q)
                FRAME: begin
                    if (de_rise) begin
                        state_d   = LINE;
                        xcnt_d    = CW'(1);
                        pix_vld_o = 1'b1;
                        pix_x_o   = '0;
                    end
                end
                LINE: begin
                    if (s1_q.de) begin
                        pix_vld_o = 1'b1;
                        if (xcnt_q == CMAX) sat_d  = 1'b1;
                        else                xcnt_d = xcnt_q + CW'(1);
                    end else begin
                        state_d = FRAME;
                        if (ycnt_q == '0)          wref_d = xcnt_q;
                        else if (xcnt_q != wref_q) werr_d = 1'b1;
                        if (ycnt_q == CMAX) sat_d  = 1'b1;
                        else                ycnt_d = ycnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q    <= '0;
            s2_q    <= '0;
            state_q <= IDLE;
            xcnt_q  <= '0;
            ycnt_q  <= '0;
            wref_q  <= '0;
            werr_q  <= 1'b0;
            sat_q   <= 1'b0;
            act_w_q <= '0;
            act_h_q <= '0;
            mcnt_q  <= '0;
        end else begin
            s1_q    <= lcd_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            xcnt_q  <= xcnt_d;
            ycnt_q  <= ycnt_d;
            wref_q  <= wref_d;
            werr_q  <= werr_d;
            sat_q   <= sat_d;
            act_w_q <= act_w_d;
            act_h_q <= act_h_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign pix_o       = s1_q;
    assign frame_bad_o = werr_q | sat_q;
    assign act_w_o     = act_w_q;
    assign act_h_o     = act_h_q;
    assign locked_o    = (mcnt_q == 2'd2);

endmodule

// File: rtl/video_grid_rx.sv
// Bit-grid readback receiver: samples the centre of each 8x8 grid
// cell and commits the recovered row registers once per frame.
module video_grid_rx
    import video_pkg::*;
#(
    parameter int   X_OFS  = GRID_X_OFS,
    parameter int   Y_OFS  = GRID_Y_OFS,
    parameter int   CELL   = GRID_CELL,
    parameter logic VS_ACT = 1'b1,
    parameter int   CW     = 12
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic           LCD_DE,
    input  logic           LCD_HSYNC,
    input  logic           LCD_VSYNC,
    input  logic [R_W-1:0] LCD_R,
    input  logic [G_W-1:0] LCD_G,
    input  logic [B_W-1:0] LCD_B,
    input  logic [2:0]     rd_sel,
    output logic [7:0]     rd_dat,
    output logic           frame_stb,
    output logic           grid_err,
    output logic           locked,
    output logic [CW-1:0]  act_w,
    output logic [CW-1:0]  act_h
);

    localparam int         LG    = $clog2(CELL);
    localparam logic [6:0] NSAMP = 7'(GRID_N * GRID_N);

    lcd_t          lcd, pix;
    logic          pix_vld, commit, frame_bad;
    logic [CW-1:0] pix_x, pix_y, dx, dy;
    logic          hit_x, hit_y, samp;
    logic [2:0]    col, row;

    logic [GRID_N-1:0][7:0] shad_q, shad_d;
    logic [GRID_N-1:0][7:0] regs_q, regs_d;
    logic [6:0]             scnt_q, scnt_d;
    logic                   cerr_q, cerr_d;
    logic                   stb_q, stb_d;
    logic                   gerr_q, gerr_d;

    assign lcd = '{de: LCD_DE, hs: LCD_HSYNC, vs: LCD_VSYNC,
                   r: LCD_R, g: LCD_G, b: LCD_B};

    video_timing_meas #(
        .CW     (CW),
        .VS_ACT (VS_ACT)
    ) u_meas (
        .clk_i       (CLK),
        .rst_ni      (nRST),
        .lcd_i       (lcd),
        .pix_o       (pix),
        .pix_vld_o   (pix_vld),
        .pix_x_o     (pix_x),
        .pix_y_o     (pix_y),
        .commit_o    (commit),
        .frame_bad_o (frame_bad),
        .act_w_o     (act_w),
        .act_h_o     (act_h),
        .locked_o    (locked)
    );

    // Cell centre: offset past the grid origin is k*CELL + CELL/2.
    assign dx    = pix_x - CW'(X_OFS);
    assign dy    = pix_y - CW'(Y_OFS);
    assign hit_x = (pix_x >= CW'(X_OFS)) && (dx[LG-1:0] == LG'(CELL / 2))
                && ((dx >> LG) < CW'(GRID_N));
    assign hit_y = (pix_y >= CW'(Y_OFS)) && (dy[LG-1:0] == LG'(CELL / 2))
                && ((dy >> LG) < CW'(GRID_N));
    assign col   = dx[LG+2:LG];
    assign row   = dy[LG+2:LG];
    assign samp  = pix_vld && hit_x && hit_y;

    always_comb begin
        shad_d = shad_q;
        regs_d = regs_q;
        scnt_d = scnt_q;
        cerr_d = cerr_q;
        gerr_d = gerr_q;
        stb_d  = 1'b0;
        if (commit) begin
            stb_d  = 1'b1;
            gerr_d = cerr_q | frame_bad | (scnt_q != NSAMP);
            if (scnt_q == NSAMP && !cerr_q) regs_d = shad_q;
            scnt_d = '0;
            cerr_d = 1'b0;
        end
        if (samp) begin
            shad_d[row][3'd7 - col] = grid_bit(pix);
            if (!pix.b[B_W-1]) cerr_d = 1'b1;
            if (scnt_d != '1) scnt_d = scnt_d + 7'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            shad_q <= '0;
            regs_q <= '0;
            scnt_q <= '0;
            cerr_q <= 1'b0;
            stb_q  <= 1'b0;
            gerr_q <= 1'b0;
        end else begin
            shad_q <= shad_d;
            regs_q <= regs_d;
            scnt_q <= scnt_d;
            cerr_q <= cerr_d;
            stb_q  <= stb_d;
            gerr_q <= gerr_d;
        end
    end

    assign rd_dat    = regs_q[rd_sel];
    assign frame_stb = stb_q;
    assign grid_err  = gerr_q;

endmodule

// File: tb/tb_video_grid_rx.sv
// Directed bench for video_grid_rx on a reduced grid geometry with a
// commit scoreboard and register readback.
module tb_video_grid_rx;

    localparam int XO   = 2;
    localparam int YO   = 1;
    localparam int CELL = 4;
    localparam int CW   = 12;
    localparam int W    = 40;
    localparam int H    = 36;
    localparam int HB   = 4;

    localparam logic [63:0] P1 = 64'h8142_2418_1824_4281;
    localparam logic [63:0] P2 = 64'hF00F_3CC3_A55A_0FF1;

    typedef struct packed {
        logic [63:0]   regs;
        logic [CW-1:0] w;
        logic [CW-1:0] h;
        logic          gerr;
        logic          lock;
    } exp_t;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          LCD_DE = 1'b0;
    logic          LCD_HSYNC = 1'b0;
    logic          LCD_VSYNC = 1'b0;
    logic [4:0]    LCD_R = '0;
    logic [5:0]    LCD_G = '0;
    logic [4:0]    LCD_B = '0;
    logic [2:0]    rd_sel = '0;
    logic [7:0]    rd_dat;
    logic          frame_stb;
    logic          grid_err;
    logic          locked;
    logic [CW-1:0] act_w;
    logic [CW-1:0] act_h;

    int checks = 0;
    int failures = 0;

    exp_t sbq[$];
    exp_t mon_e;

    logic [63:0] m_regs = '0;
    int          m_w = 0;
    int          m_h = 0;
    int          m_mcnt = 0;
    bit          m_active = 0;

    int          f_w = 0;
    int          f_h = 0;
    bit          f_werr = 0;
    bit          f_cerr = 0;
    int          f_samp = 0;
    logic [63:0] f_pat = '0;

    video_grid_rx #(
        .X_OFS  (XO),
        .Y_OFS  (YO),
        .CELL   (CELL),
        .VS_ACT (1'b1),
        .CW     (CW)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .LCD_DE    (LCD_DE),
        .LCD_HSYNC (LCD_HSYNC),
        .LCD_VSYNC (LCD_VSYNC),
        .LCD_R     (LCD_R),
        .LCD_G     (LCD_G),
        .LCD_B     (LCD_B),
        .rd_sel    (rd_sel),
        .rd_dat    (rd_dat),
        .frame_stb (frame_stb),
        .grid_err  (grid_err),
        .locked    (locked),
        .act_w     (act_w),
        .act_h     (act_h)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (frame_stb === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("stb_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("act_w", 64'(act_w), 64'(mon_e.w));
                chk("act_h", 64'(act_h), 64'(mon_e.h));
                chk("grid_err", 64'(grid_err), 64'(mon_e.gerr));
                chk("locked", 64'(locked), 64'(mon_e.lock));
            end
        end
    end

    function automatic logic [15:0] color(input logic [63:0] pat,
        input int x, input int y, input int br, input int bc);
        int c, r;
        if (x < XO || y < YO) return 16'h0000;
        c = (x - XO) / CELL;
        r = (y - YO) / CELL;
        if (c > 7 || r > 7) return 16'h0000;
        if (r == br && c == bc) return 16'h0000;
        return pat[(7 - r) * 8 + (7 - c)] ? 16'hFFFF : 16'h001F;
    endfunction

    task automatic drive(input logic de, input logic vs,
                         input logic [15:0] rgb);
        @(negedge CLK);
        LCD_DE    = de;
        LCD_VSYNC = vs;
        LCD_HSYNC = !de;
        {LCD_R, LCD_G, LCD_B} = rgb;
    endtask

    task automatic model_commit();
        exp_t e;
        bit   match;
        if (!m_active) return;
        match  = (f_w == m_w) && (f_h == m_h) && !f_werr;
        m_mcnt = match ? ((m_mcnt == 2) ? 2 : m_mcnt + 1) : 0;
        m_w    = f_w;
        m_h    = f_h;
        if (f_samp == 64 && !f_cerr) m_regs = f_pat;
        e.regs = m_regs;
        e.w    = CW'(m_w);
        e.h    = CW'(m_h);
        e.gerr = f_cerr || f_werr || (f_samp != 64);
        e.lock = (m_mcnt == 2);
        sbq.push_back(e);
    endtask

    task automatic vsync();
        model_commit();
        m_active = 1;
        repeat (2) drive(1'b0, 1'b1, 16'h0);
        repeat (3) drive(1'b0, 1'b0, 16'h0);
    endtask

    task automatic send_frame(input logic [63:0] pat, input int nl,
        input int bad_l, input int br, input int bc, input bit vs_first);
        int w;
        int rows;
        for (int y = 0; y < nl; y++) begin
            w = (y == bad_l) ? W - 1 : W;
            for (int x = 0; x < w; x++)
                drive(1'b1, vs_first && y == 0 && x < 2,
                      color(pat, x, y, br, bc));
            repeat (HB) drive(1'b0, 1'b0, 16'h0);
        end
        rows = 0;
        for (int r = 0; r < 8; r++)
            if (YO + CELL * r + CELL / 2 < nl) rows++;
        f_w    = W;
        f_h    = nl;
        f_werr = (bad_l > 0) && (bad_l < nl);
        f_cerr = (br >= 0) && (YO + CELL * br + CELL / 2 < nl);
        f_samp = rows * 8;
        f_pat  = pat;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            @(negedge CLK);
            #1;
        end
        chk(tag, 64'(sbq.size()), 64'd0);
    endtask

    task automatic read_regs(input string tag);
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            #1;
            chk(tag, 64'(rd_dat), 64'(m_regs[(7 - s) * 8 +: 8]));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stb"}, 64'(frame_stb), 64'd0);
        chk({tag, "_gerr"}, 64'(grid_err), 64'd0);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
        chk({tag, "_act_w"}, 64'(act_w), 64'd0);
        chk({tag, "_act_h"}, 64'(act_h), 64'd0);
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            #1;
            chk({tag, "_rd_dat"}, 64'(rd_dat), 64'd0);
        end
    endtask

    initial begin
        repeat (4) @(negedge CLK);
        #1;
        check_zero("reset");
        @(negedge CLK);
        nRST = 1'b1;

        vsync();
        send_frame(P1, H, -1, -1, -1, 1'b0);
        vsync();
        drain("sb_commit1");
        read_regs("regs_c1");
        send_frame(P1, H, -1, -1, -1, 1'b0);
        vsync();
        send_frame(P1, H, -1, -1, -1, 1'b0);
        vsync();
        drain("sb_commit3");
        read_regs("regs_c3");

        send_frame(P2, H, -1, 3, 5, 1'b0);
        vsync();
        drain("sb_black");
        read_regs("regs_black");
        send_frame(P2, H, -1, -1, -1, 1'b0);
        vsync();
        drain("sb_clean");
        read_regs("regs_clean");

        send_frame(P1, 20, -1, -1, -1, 1'b0);
        vsync();
        drain("sb_short");
        read_regs("regs_short");
        send_frame(P1, H, -1, -1, -1, 1'b0);
        vsync();

        send_frame(P2, H, 20, -1, -1, 1'b0);
        vsync();
        drain("sb_wmis");
        read_regs("regs_wmis");

        send_frame(P1, H, -1, -1, -1, 1'b0);
        model_commit();
        send_frame(P2, H, -1, -1, -1, 1'b1);
        vsync();
        drain("sb_vs_de");
        read_regs("regs_vs_de");

        send_frame(P1, 10, -1, -1, -1, 1'b0);
        repeat (5) drive(1'b1, 1'b0, 16'hFFFF);
        nRST = 1'b0;
        repeat (4) drive(1'b1, 1'b0, 16'hFFFF);
        #1;
        check_zero("midreset");
        m_active = 0;
        m_regs   = '0;
        m_w      = 0;
        m_h      = 0;
        m_mcnt   = 0;
        drive(1'b0, 1'b0, 16'h0);
        nRST = 1'b1;
        vsync();
        send_frame(P1, H, -1, -1, -1, 1'b0);
        vsync();
        drain("sb_after_reset");
        read_regs("regs_after_reset");

        repeat (10) drive(1'b0, 1'b0, 16'h0);
        drain("sb_final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
